// File: rtl/md_audio_mixer_if.sv
// Sample stream port between the audio mixer and the board-level DAC/I2S serializer.
`timescale 1ns/1ps
interface md_audio_mixer_if;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_l;
    logic [15:0] out_r;

    modport master (output out_valid, output out_l, output out_r, input out_ready);
    modport slave  (input out_valid, input out_l, input out_r, output out_ready);
endinterface

// File: rtl/md_audio_mixer.sv
// Box-filters YM3438 stereo and PSG levels over 2^DECIM_LOG2 MCLK cycles, then mixes
// and saturates them into a 16-bit signed stereo stream behind a valid/ready port.
`timescale 1ns/1ps
module md_audio_mixer #(
    parameter int          DECIM_LOG2 = 10,
    parameter int          FM_SHIFT   = 5,
    parameter int          PSG_SHIFT  = 2,
    parameter logic [15:0] PSG_BIAS   = 16'h0000
) (
    input  logic                MCLK,
    input  logic                RESET,
    input  logic                fm_sample_en,
    input  logic signed [9:0]   MOL_2612,
    input  logic signed [9:0]   MOR_2612,
    input  logic                psg_sample_en,
    input  logic [15:0]         PSG,
    input  logic                mute,
    md_audio_mixer_if.master    out_if,
    output logic                overrun
);
    localparam int AW = 10 + DECIM_LOG2;
    localparam int PW = 16 + DECIM_LOG2;

    logic [DECIM_LOG2-1:0] r_cnt;
    logic                  w_tc;
    logic                  r_s1_valid;
    logic                  r_out_valid;
    logic                  r_overrun;
    logic [15:0]           r_psg_hold;
    logic [PW-1:0]         r_acc_p;
    logic [PW-1:0]         w_acc_p_sum;
    logic [15:0]           r_avg_p;
    logic signed [16:0]    w_psg_diff;
    logic signed [16:0]    w_psg_shr;
    logic signed [17:0]    w_psg_term;
    logic signed [9:0]     w_fm_in [2];
    logic [15:0]           w_out [2];

    assign w_tc       = &r_cnt;
    assign w_fm_in[0] = MOL_2612;
    assign w_fm_in[1] = MOR_2612;

    // The hold value current at the start of the cycle is summed; a strobe only
    // changes what the next cycle sees.
    assign w_acc_p_sum = r_acc_p + {{DECIM_LOG2{1'b0}}, r_psg_hold};

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            r_cnt      <= '0;
            r_s1_valid <= 1'b0;
            r_psg_hold <= '0;
            r_acc_p    <= '0;
            r_avg_p    <= '0;
        end else begin
            r_cnt      <= r_cnt + 1'b1;
            r_s1_valid <= w_tc;
            if (psg_sample_en) begin
                r_psg_hold <= PSG;
            end
            if (w_tc) begin
                r_avg_p <= w_acc_p_sum[PW-1:DECIM_LOG2];
                r_acc_p <= '0;
            end else begin
                r_acc_p <= w_acc_p_sum;
            end
        end
    end

    assign w_psg_diff = $signed({1'b0, r_avg_p}) - $signed({1'b0, PSG_BIAS});
    assign w_psg_shr  = w_psg_diff >>> PSG_SHIFT;
    assign w_psg_term = {w_psg_shr[16], w_psg_shr};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fm
            logic signed [9:0]    r_hold;
            logic signed [AW-1:0] r_acc;
            logic signed [AW-1:0] w_acc_sum;
            logic signed [9:0]    r_avg;
            logic signed [17:0]   w_fm_term;
            logic signed [17:0]   w_mix;
            logic [15:0]          w_sample;
            logic [15:0]          r_out;

            assign w_acc_sum = r_acc + {{DECIM_LOG2{r_hold[9]}}, r_hold};
            assign w_fm_term = {{8{r_avg[9]}}, r_avg} <<< FM_SHIFT;
            assign w_mix     = w_fm_term + w_psg_term;

            always_comb begin
                w_sample = w_mix[15:0];
                if (mute) begin
                    w_sample = 16'h0000;
                end else if (w_mix > 18'sd32767) begin
                    w_sample = 16'h7FFF;
                end else if (w_mix < -18'sd32768) begin
                    w_sample = 16'h8000;
                end
            end

            always_ff @(posedge MCLK) begin
                if (RESET) begin
                    r_hold <= '0;
                    r_acc  <= '0;
                    r_avg  <= '0;
                    r_out  <= '0;
                end else begin
                    if (fm_sample_en) begin
                        r_hold <= w_fm_in[gi];
                    end
                    if (w_tc) begin
                        r_avg <= w_acc_sum[AW-1:DECIM_LOG2];
                        r_acc <= '0;
                    end else begin
                        r_acc <= w_acc_sum;
                    end
                    if (r_s1_valid) begin
                        r_out <= w_sample;
                    end
                end
            end

            assign w_out[gi] = r_out;
        end
    endgenerate

    // A fresh mix always wins over a transfer; losing an unread sample is sticky.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (r_s1_valid) begin
            r_out_valid <= 1'b1;
            if (r_out_valid && !out_if.out_ready) begin
                r_overrun <= 1'b1;
            end
        end else if (r_out_valid && out_if.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_if.out_valid = r_out_valid;
    assign out_if.out_l     = w_out[0];
    assign out_if.out_r     = w_out[1];
    assign overrun          = r_overrun;
endmodule

// File: tb/tb_md_audio_mixer.sv
// Bench for md_audio_mixer: six parameterisations driven from shared stimulus, checked
// against hand-derived constants and a window-sum reference model.
`timescale 1ns/1ps
module tb_md_audio_mixer;
    localparam int NDUT = 6;

    function automatic int p_dl(int i);
        case (i)
            0:       return 10;
            5:       return 3;
            default: return 2;
        endcase
    endfunction
    function automatic int p_fs(int i);
        case (i)
            2:       return 0;
            3, 4:    return 6;
            default: return 5;
        endcase
    endfunction
    function automatic logic [15:0] p_pb(int i);
        return (i == 4) ? 16'h8000 : 16'h0000;
    endfunction

    logic        MCLK = 1'b0;
    logic        RESET;
    logic        fm_en;
    logic        psg_en;
    logic [9:0]  mol;
    logic [9:0]  mor;
    logic [15:0] psg;
    logic        mute;
    logic        ready_i [NDUT];
    logic        valid_o [NDUT];
    logic [15:0] l_o [NDUT];
    logic [15:0] r_o [NDUT];
    logic        ovr_o [NDUT];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 MCLK = ~MCLK;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        md_audio_mixer_if bus ();
        assign bus.out_ready = ready_i[gi];
        md_audio_mixer #(
            .DECIM_LOG2(p_dl(gi)),
            .FM_SHIFT  (p_fs(gi)),
            .PSG_SHIFT (2),
            .PSG_BIAS  (p_pb(gi))
        ) u_dut (
            .MCLK         (MCLK),
            .RESET        (RESET),
            .fm_sample_en (fm_en),
            .MOL_2612     (mol),
            .MOR_2612     (mor),
            .psg_sample_en(psg_en),
            .PSG          (psg),
            .mute         (mute),
            .out_if       (bus.master),
            .overrun      (ovr_o[gi])
        );
        assign valid_o[gi] = bus.out_valid;
        assign l_o[gi]     = bus.out_l;
        assign r_o[gi]     = bus.out_r;
    end

    task automatic tick();
        @(posedge MCLK);
        #1;
        cyc++;
    endtask

    // Leaves the bench in the first non-reset cycle, numbered 0.
    task automatic do_reset(int n);
        RESET = 1'b1; fm_en = 1'b0; psg_en = 1'b0; mute = 1'b0;
        mol = '0; mor = '0; psg = '0;
        for (int d = 0; d < NDUT; d++) ready_i[d] = 1'b1;
        repeat (n) tick();
        RESET = 1'b0;
        cyc = 0;
    endtask

    function automatic logic [15:0] mix_ref(int fm, int p, int fs, int ps, int bias, bit m);
        int s;
        s = fm * (1 << fs) + ((p - bias) >>> ps);
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return m ? 16'h0000 : 16'(s);
    endfunction

    task automatic test_reset();
        int first;
        logic [15:0] fl, fr;
        RESET = 1'b1; fm_en = 1'b0; psg_en = 1'b0; mute = 1'b0;
        mol = '0; mor = '0; psg = '0;
        for (int d = 0; d < NDUT; d++) ready_i[d] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({valid_o[0], ovr_o[0], l_o[0], r_o[0]} !== 34'd0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got v=%0b o=%0b l=%h r=%h exp all 0", i, valid_o[0], ovr_o[0], l_o[0], r_o[0]);
            end
        end
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if ({valid_o[d], ovr_o[d], l_o[d], r_o[d]} !== 34'd0) begin
                failures++;
                $display("FAIL reset_state dut=%0d got v=%0b o=%0b l=%h r=%h exp all 0", d, valid_o[d], ovr_o[d], l_o[d], r_o[d]);
            end
        end
        RESET = 1'b0;
        cyc = 0;
        first = -1; fl = '1; fr = '1;
        while (cyc < 1030) begin
            tick();
            if (valid_o[0] === 1'b1 && first < 0) begin
                first = cyc; fl = l_o[0]; fr = r_o[0];
            end
        end
        checks++;
        if (first !== 1025) begin
            failures++;
            $display("FAIL reset_first_valid got=%0d exp=1025", first);
        end
        checks++;
        if ({fl, fr} !== 32'd0) begin
            failures++;
            $display("FAIL reset_first_sample got l=%h r=%h exp 0000 0000", fl, fr);
        end
    endtask

    task automatic test_const_fm();
        logic exp_v;
        do_reset(2);
        mol = 10'h100; mor = 10'h3C0; fm_en = 1'b1;
        tick();
        fm_en = 1'b0;
        while (cyc < 20) begin
            tick();
            exp_v = (cyc >= 5) && ((cyc - 5) % 4 == 0);
            checks++;
            if (valid_o[1] !== exp_v) begin
                failures++;
                $display("FAIL const_valid cyc=%0d got=%0b exp=%0b", cyc, valid_o[1], exp_v);
            end
            if (exp_v && cyc >= 9) begin
                checks++;
                if (l_o[1] !== 16'h2000 || r_o[1] !== 16'hF800) begin
                    failures++;
                    $display("FAIL const_sample cyc=%0d got l=%h r=%h exp 2000 F800", cyc, l_o[1], r_o[1]);
                end
            end
        end
    endtask

    task automatic test_averaging();
        logic [15:0] exp_l;
        do_reset(2);
        while (cyc < 26) begin
            fm_en = (cyc <= 14);
            mol   = (cyc % 2 == 0) ? 10'd4 : 10'd0;
            tick();
            if (cyc >= 5 && cyc % 4 == 1) begin
                exp_l = (cyc >= 21) ? 16'd4 : 16'd2;
                checks++;
                if (valid_o[2] !== 1'b1 || l_o[2] !== exp_l || r_o[2] !== 16'd0) begin
                    failures++;
                    $display("FAIL avg_sample cyc=%0d got v=%0b l=%h r=%h exp v=1 l=%h r=0000", cyc, valid_o[2], l_o[2], r_o[2], exp_l);
                end
            end
        end
        fm_en = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset(2);
        mol = 10'h1FF; mor = 10'h000; psg = 16'hFFFF; fm_en = 1'b1; psg_en = 1'b1;
        tick();
        fm_en = 1'b0; psg_en = 1'b0;
        while (cyc < 9) tick();
        checks++;
        if (valid_o[3] !== 1'b1 || l_o[3] !== 16'h7FFF || r_o[3] !== 16'h3FFF) begin
            failures++;
            $display("FAIL sat_pos got v=%0b l=%h r=%h exp v=1 l=7FFF r=3FFF", valid_o[3], l_o[3], r_o[3]);
        end
        checks++;
        if (l_o[4] !== 16'h7FFF || r_o[4] !== 16'h1FFF) begin
            failures++;
            $display("FAIL sat_pos_bias got l=%h r=%h exp l=7FFF r=1FFF", l_o[4], r_o[4]);
        end
        do_reset(2);
        mol = 10'h200; mor = 10'h000; psg = 16'h0000; fm_en = 1'b1; psg_en = 1'b1;
        tick();
        fm_en = 1'b0; psg_en = 1'b0;
        while (cyc < 9) tick();
        checks++;
        if (valid_o[3] !== 1'b1 || l_o[3] !== 16'h8000 || r_o[3] !== 16'h0000) begin
            failures++;
            $display("FAIL sat_neg got v=%0b l=%h r=%h exp v=1 l=8000 r=0000", valid_o[3], l_o[3], r_o[3]);
        end
        checks++;
        if (l_o[4] !== 16'h8000 || r_o[4] !== 16'hE000) begin
            failures++;
            $display("FAIL sat_bias got l=%h r=%h exp l=8000 r=E000", l_o[4], r_o[4]);
        end
    endtask

    task automatic test_handshake();
        do_reset(2);
        ready_i[1] = 1'b0; mol = 10'h100; mor = 10'h000; fm_en = 1'b1;
        tick();
        fm_en = 1'b0;
        while (cyc < 22) begin
            ready_i[1] = (cyc >= 10);
            tick();
            if (cyc >= 5 && cyc <= 8) begin
                checks++;
                if (valid_o[1] !== 1'b1 || l_o[1] !== 16'h1800 || ovr_o[1] !== 1'b0) begin
                    failures++;
                    $display("FAIL hs_stall cyc=%0d got v=%0b l=%h o=%0b exp v=1 l=1800 o=0", cyc, valid_o[1], l_o[1], ovr_o[1]);
                end
            end
            if (cyc == 9 || cyc == 13) begin
                checks++;
                if (valid_o[1] !== 1'b1 || l_o[1] !== 16'h2000 || ovr_o[1] !== 1'b1) begin
                    failures++;
                    $display("FAIL hs_overrun cyc=%0d got v=%0b l=%h o=%0b exp v=1 l=2000 o=1", cyc, valid_o[1], l_o[1], ovr_o[1]);
                end
            end
            if (cyc == 11) begin
                checks++;
                if (valid_o[1] !== 1'b0) begin
                    failures++;
                    $display("FAIL hs_drain got v=%0b exp v=0", valid_o[1]);
                end
            end
        end
        checks++;
        if (ovr_o[1] !== 1'b1) begin
            failures++;
            $display("FAIL hs_sticky got o=%0b exp o=1", ovr_o[1]);
        end
        do_reset(1);
        checks++;
        if (ovr_o[1] !== 1'b0) begin
            failures++;
            $display("FAIL hs_clear got o=%0b exp o=0", ovr_o[1]);
        end
        mol = 10'h100; fm_en = 1'b1;
        tick();
        fm_en = 1'b0;
        while (cyc < 11) begin
            ready_i[1] = !(cyc >= 5 && cyc <= 7);
            tick();
            if (cyc == 9) begin
                checks++;
                if (valid_o[1] !== 1'b1 || l_o[1] !== 16'h2000 || ovr_o[1] !== 1'b0) begin
                    failures++;
                    $display("FAIL hs_tolerance got v=%0b l=%h o=%0b exp v=1 l=2000 o=0", valid_o[1], l_o[1], ovr_o[1]);
                end
            end
            if (cyc == 10) begin
                checks++;
                if (valid_o[1] !== 1'b0) begin
                    failures++;
                    $display("FAIL hs_accept got v=%0b exp v=0", valid_o[1]);
                end
            end
        end
    endtask

    task automatic test_mute_reset();
        do_reset(2);
        mol = 10'd100; mor = 10'h39C; fm_en = 1'b1;
        tick();
        fm_en = 1'b0;
        while (cyc < 29) begin
            mute = (cyc == 16);
            tick();
            if (cyc == 9 || cyc == 17 || cyc == 25) begin
                logic [15:0] el, er;
                el = (cyc == 9) ? 16'h0AE0 : (cyc == 17) ? 16'h0000 : 16'h0C80;
                er = (cyc == 9) ? 16'hF500 : (cyc == 17) ? 16'h0000 : 16'hF380;
                checks++;
                if (valid_o[5] !== 1'b1 || l_o[5] !== el || r_o[5] !== er) begin
                    failures++;
                    $display("FAIL mute_sample cyc=%0d got v=%0b l=%h r=%h exp v=1 l=%h r=%h", cyc, valid_o[5], l_o[5], r_o[5], el, er);
                end
            end
        end
        mute = 1'b0;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        cyc = 0;
        fm_en = 1'b1;
        tick();
        fm_en = 1'b0;
        while (cyc < 12) begin
            tick();
            checks++;
            if (valid_o[5] !== (cyc == 9)) begin
                failures++;
                $display("FAIL midreset_valid cyc=%0d got=%0b exp=%0b", cyc, valid_o[5], (cyc == 9));
            end
            if (cyc == 9) begin
                checks++;
                if (l_o[5] !== 16'h0AE0 || r_o[5] !== 16'hF500) begin
                    failures++;
                    $display("FAIL midreset_sample got l=%h r=%h exp l=0AE0 r=F500", l_o[5], r_o[5]);
                end
            end
        end
    endtask

    task automatic test_random();
        int hist_l[$], hist_r[$], hist_p[$];
        int h_l, h_r, h_p, v_l, v_r, v_p, sl, sr, sp;
        bit s1, e_v, e_o, b_fm, b_psg, b_mute, b_rdy;
        int a_l, a_r, a_p;
        logic [15:0] e_l, e_r;
        do_reset(2);
        h_l = 0; h_r = 0; h_p = 0; s1 = 0; e_v = 0; e_o = 0; e_l = '0; e_r = '0;
        a_l = 0; a_r = 0; a_p = 0;
        for (int n = 0; n < 400; n++) begin
            checks++;
            if (valid_o[1] !== e_v || l_o[1] !== e_l || r_o[1] !== e_r || ovr_o[1] !== e_o) begin
                failures++;
                $display("FAIL random cyc=%0d got v=%0b l=%h r=%h o=%0b exp v=%0b l=%h r=%h o=%0b",
                         n, valid_o[1], l_o[1], r_o[1], ovr_o[1], e_v, e_l, e_r, e_o);
            end
            b_fm   = ($urandom_range(0, 3) == 0);
            b_psg  = ($urandom_range(0, 3) == 0);
            b_mute = ($urandom_range(0, 9) == 0);
            b_rdy  = ($urandom_range(0, 9) < 8);
            v_l = int'($urandom_range(0, 1023)) - 512;
            v_r = int'($urandom_range(0, 1023)) - 512;
            v_p = int'($urandom_range(0, 65535));
            fm_en = b_fm; psg_en = b_psg; mute = b_mute; ready_i[1] = b_rdy;
            mol = 10'(v_l); mor = 10'(v_r); psg = 16'(v_p);
            hist_l.push_back(h_l); hist_r.push_back(h_r); hist_p.push_back(h_p);
            if (s1) begin
                if (e_v && !b_rdy) e_o = 1;
                e_v = 1;
                e_l = mix_ref(a_l, a_p, 5, 2, 0, b_mute);
                e_r = mix_ref(a_r, a_p, 5, 2, 0, b_mute);
            end else if (e_v && b_rdy) begin
                e_v = 0;
            end
            s1 = (n % 4 == 3);
            if (s1) begin
                sl = 0; sr = 0; sp = 0;
                for (int k = 1; k <= 4; k++) begin
                    sl += hist_l[hist_l.size() - k];
                    sr += hist_r[hist_r.size() - k];
                    sp += hist_p[hist_p.size() - k];
                end
                a_l = sl >>> 2; a_r = sr >>> 2; a_p = sp >>> 2;
            end
            if (b_fm) begin h_l = v_l; h_r = v_r; end
            if (b_psg) h_p = v_p;
            tick();
        end
        fm_en = 1'b0; psg_en = 1'b0; mute = 1'b0;
    endtask

    initial begin
        test_reset();
        test_const_fm();
        test_averaging();
        test_saturation();
        test_handshake();
        test_mute_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/md_audio_mixer.md
# md_audio_mixer

Downstream audio stage for the chipset top level: captures the signed 10-bit YM3438 stereo outputs (MOL_2612/MOR_2612) and the 16-bit unsigned PSG level, and box-filters each over a fixed power-of-two window of MCLK cycles. It then mixes and saturates them into a 16-bit signed stereo sample stream. Output uses a valid/ready handshake toward the board-level DAC/I2S serializer, with overrun detection and mute.

## Interface
Parameters:
- DECIM_LOG2, 10, window length is 2^DECIM_LOG2 MCLK cycles (1..12).
- FM_SHIFT, 5, left shift applied to averaged FM value (0..6).
- PSG_SHIFT, 2, arithmetic right shift applied to bias-removed PSG (0..8).
- PSG_BIAS, 16'h0000, unsigned DC offset subtracted from averaged PSG.

Ports:
- MCLK  in  1  master clock; the only clock.
- RESET  in  1  synchronous, active-high reset.
- fm_sample_en  in  1  one-cycle strobe; MOL_2612/MOR_2612 valid this cycle.
- MOL_2612  in  10  FM left, two's complement.
- MOR_2612  in  10  FM right, two's complement.
- psg_sample_en  in  1  one-cycle strobe; PSG valid this cycle.
- PSG  in  16  PSG mono level, unsigned.
- mute  in  1  forces emitted samples to zero.
- out_ready  in  1  consumer accepts sample when out_valid & out_ready.
- out_valid  out  1  sample pending.
- out_l  out  16  left sample, signed.
- out_r  out  16  right sample, signed.
- overrun  out  1  sticky: a pending sample was overwritten.

## Operation
- Hold registers fm_l, fm_r (10b signed) and psg_h (16b) load on their strobes. They are zero after reset. Unstrobed cycles reuse the held value (zero-order hold).
- The window counter is DECIM_LOG2 bits and increments every cycle, wrapping at 2^DECIM_LOG2-1 (the terminal cycle, "TC").
- The accumulators are acc_l and acc_r (10+DECIM_LOG2 bits, signed) and acc_p (16+DECIM_LOG2 bits, unsigned). Each cycle they add the value the hold register has at the start of that cycle. A strobe in the same cycle affects the next cycle only.
- On TC:
  - The stage-1 registers take the accumulator sum including this cycle's term, arithmetically shifted right by DECIM_LOG2: avg_l and avg_r (10b signed), avg_p (16b).
  - The accumulators restart at 0 (no term dropped or doubled).
  - A stage-1 valid flag is set for one cycle.
- Stage 2 (mix) computes one 18-bit signed sum per channel: sum = (avg_fm <<< FM_SHIFT) + (({1'b0,avg_p} - {1'b0,PSG_BIAS}) >>> PSG_SHIFT).
  - The result clamps to [-32768, 32767].
  - If mute is high in the stage-2 cycle, both channels are 0.
  - The result loads out_l/out_r and sets out_valid.
- Handshake:
  - The output registers hold steady while out_valid & ~out_ready.
  - A transfer clears out_valid unless a new stage-2 load occurs in the same cycle; the load wins and out_valid stays 1.
  - A stage-2 load while out_valid=1 and out_ready=0 overwrites the sample and sets overrun.
  - overrun clears only on RESET.
- Reset values: out_valid=0, out_l=out_r=0, overrun=0, counter=0, accumulators/holds/averages=0, stage-1 valid=0.

## Timing
- Window TC at cycle k: avg registers valid at k+1; out_valid=1 and new out_l/out_r visible at k+2.
- First out_valid after RESET deassertion occurs exactly 2^DECIM_LOG2+1 cycles after the first non-reset cycle. The first non-reset cycle has counter=0.
- Steady state: one sample every 2^DECIM_LOG2 cycles.
- Consumer stall tolerance is up to 2^DECIM_LOG2-1 cycles without overrun.
- mute is sampled in the stage-2 cycle (k+1) only. It does not affect accumulation.
- RESET mid-window discards the partial accumulation and any pending sample. The counter restarts at 0 on the cycle after RESET deasserts.
- Strobe on TC: the new value enters the next window, not the closing one.

## Test plan
- Reset/idle check: assert RESET 4 cycles with out_ready=1 and default params.
  - All outputs are 0 during and after reset.
  - out_valid first rises 1025 cycles after release, with out_l=out_r=0.
- Constant FM: DECIM_LOG2=2, FM_SHIFT=5, PSG=0.
  - Stimulus: strobe MOL_2612=10'h100 and MOR_2612=10'h3C0 (-64) once.
  - From the first full window after the strobe: out_l=16'h2000, out_r=16'hF800, one sample every 4 cycles.
- Averaging and hold: DECIM_LOG2=2, FM_SHIFT=0.
  - Stimulus: strobe MOL_2612 alternately 10'h004 and 10'h000 every cycle.
  - Result: out_l=2 each window.
  - Then stop strobing with hold=4: out_l=4 from the next full window.
- Saturation: FM_SHIFT=6, PSG_SHIFT=2, PSG_BIAS=0.
  - Case 1: MOL=+511, PSG=16'hFFFF gives out_l=16'h7FFF.
  - Case 2: MOL=-512, PSG=0 gives out_l=16'h8000.
  - Case 3: PSG_BIAS=16'h8000, PSG=0, MOR=0 gives out_r=-8192 (16'hE000).
- Handshake/overrun: DECIM_LOG2=2, out_ready=0 for 10 cycles, then 1.
  - out_l/out_r stay stable while stalled.
  - The second window result overwrites the first and sets overrun=1.
  - overrun remains 1 after out_ready returns, until RESET.
- Mute and mid-window reset: DECIM_LOG2=3 with nonzero FM input.
  - Pulse mute in the cycle after TC: that sample is exactly 0, and neighbouring samples are nonzero.
  - Assert RESET 1 cycle at counter=5: no sample from the interrupted window. Next out_valid arrives 9 cycles after reset release.
